// File: rtl/mac_acc_requant.sv
// mac_acc_requant: downstream stage of the MAC processing element.
// Sums a variable-length run of full-width Q(2I).(2F) terms in a guard-bit
// accumulator, then rounds (half toward +inf), shifts back to F fraction bits
// and saturates to the native Q(I).(F) word. The result sits in a one-entry
// output register with sat/err flags and the run's term count.
//
// Handshake: a beat or result moves on a rising edge where valid && ready are
// both high. Data must be stable while valid is high and ready is low. Here
// in_ready = !out_valid || out_ready, so the only input backpressure comes from
// a result waiting in the output register. While stalled, the accumulator
// freezes and in_data/in_last/in_valid are ignored.
//
// State: the run counter r_cnt (EMPTY when 0, ACCUM when >0) and r_out_valid
// (HOLD) are independent. Both are plain registers, so checkers can bind
// to them directly.
module mac_acc_requant #(
  parameter int para_int_bits  = 7,
  parameter int para_frac_bits = 9,
  parameter int para_max_terms = 64
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [2*(para_int_bits+para_frac_bits)-1:0]   in_data,
  input  logic                                          in_last,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [para_int_bits+para_frac_bits-1:0]       out_data,
  output logic                                          out_sat,
  output logic                                          out_err,
  output logic [$clog2(para_max_terms):0]               out_count
);

  localparam int W     = para_int_bits + para_frac_bits;
  localparam int F     = para_frac_bits;
  localparam int CW    = $clog2(para_max_terms) + 1;
  localparam int ACC_W = 2 * W + $clog2(para_max_terms);

  localparam logic [CW-1:0]        MAX_CNT = CW'(para_max_terms);
  localparam logic signed [ACC_W:0] RND    = (ACC_W+1)'(1) << (F - 1);
  localparam logic [W-1:0]         SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]         SAT_MIN = {1'b1, {(W-1){1'b0}}};

  logic signed [ACC_W-1:0] r_acc;
  logic [CW-1:0]           r_cnt;
  logic                    r_out_valid;
  logic [W-1:0]            r_out_data;
  logic                    r_out_sat;
  logic                    r_out_err;
  logic [CW-1:0]           r_out_count;

  logic                    w_in_ready;
  logic                    w_accept;
  logic [CW-1:0]           w_cnt_next;
  logic                    w_final;
  logic signed [ACC_W-1:0] w_in_ext;
  logic signed [ACC_W-1:0] w_total;
  logic signed [ACC_W:0]   w_total_x;
  logic signed [ACC_W:0]   w_rounded;
  logic signed [ACC_W:0]   w_shifted;
  logic [ACC_W-W+1:0]      w_hi;
  logic                    w_no_clip;
  logic [W-1:0]            w_sat_data;

  // Handshake, run termination and the round/shift/saturate datapath on T.
  // The rounding add uses one extra bit: a full run of maximum positive
  // terms sits just below the accumulator's top and +2^(F-1) would wrap.
  always_comb begin
    w_in_ready = !r_out_valid || out_ready;
    w_accept   = in_valid && w_in_ready;
    w_cnt_next = r_cnt + CW'(1);
    w_final    = in_last || (w_cnt_next == MAX_CNT);
    w_in_ext   = {{(ACC_W-2*W){in_data[2*W-1]}}, in_data};
    w_total    = r_acc + w_in_ext;
    w_total_x  = {w_total[ACC_W-1], w_total};
    w_rounded  = w_total_x + RND;
    w_shifted  = w_rounded >>> F;
    // The value fits in W bits only if every bit from W-1 up is a sign copy.
    w_hi       = w_shifted[ACC_W:W-1];
    w_no_clip  = (&w_hi) || (~|w_hi);
    if (w_no_clip) begin
      w_sat_data = w_shifted[W-1:0];
    end else if (w_shifted[ACC_W]) begin
      w_sat_data = SAT_MIN;
    end else begin
      w_sat_data = SAT_MAX;
    end
  end

  // Accumulator and term counter: add non-final beats, clear on the final one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (w_final) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_total;
        r_cnt <= w_cnt_next;
      end
    end
  end

  // Output register: load on a final beat (this also covers drain-and-load in
  // the same cycle with no bubble), clear valid on a plain drain, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_out_err   <= 1'b0;
      r_out_count <= '0;
    end else if (w_accept && w_final) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sat_data;
      r_out_sat   <= !w_no_clip;
      r_out_err   <= !in_last;
      r_out_count <= w_cnt_next;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign out_err   = r_out_err;
  assign out_count = r_out_count;

endmodule

// File: tb/tb_mac_acc_requant.sv
// Testbench for mac_acc_requant: directed cases plus random runs. The driver
// updates a behavioural model (integer sum, term count) for each accepted
// beat and pushes the expected result at the end of each run. A monitor pops
// and compares on every output transfer.
module tb_mac_acc_requant;

  localparam int IB  = 7;
  localparam int FB  = 9;
  localparam int MT  = 64;
  localparam int W   = IB + FB;
  localparam int DW  = 2 * W;
  localparam int CW  = $clog2(MT) + 1;
  localparam int EW  = 2 + CW + W;   // {sat, err, count, data}

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_sat;
  logic          out_err;
  logic [CW-1:0] out_count;

  always #5 clk = ~clk;

  mac_acc_requant #(
    .para_int_bits (IB),
    .para_frac_bits(FB),
    .para_max_terms(MT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat),
    .out_err  (out_err),
    .out_count(out_count)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  bit            rand_ready = 1'b0;

  // Behavioural model of the run in progress.
  longint        m_sum = 0;
  int            m_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Expected packed result for a finished run: round half up, floor-shift,
  // clamp to the native signed range.
  function automatic logic [EW-1:0] model_result(input longint sum, input int n, input bit err);
    longint        q;
    bit            sat;
    logic [W-1:0]  d;
    logic [CW-1:0] c;
    q   = (sum + (longint'(1) << (FB - 1))) >>> FB;
    sat = 1'b0;
    if (q > ((longint'(1) << (W - 1)) - 1)) begin
      q   = (longint'(1) << (W - 1)) - 1;
      sat = 1'b1;
    end else if (q < -(longint'(1) << (W - 1))) begin
      q   = -(longint'(1) << (W - 1));
      sat = 1'b1;
    end
    d = W'(q);
    c = CW'(n);
    return {sat, err, c, d};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(out_valid), 64'(0));
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("out_data",  64'(out_data),  64'(e[W-1:0]));
        check("out_count", 64'(out_count), 64'(e[W+CW-1:W]));
        check("out_err",   64'(out_err),   64'(e[W+CW]));
        check("out_sat",   64'(out_sat),   64'(e[W+CW+1]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Present one beat until it is accepted, then update the model.
  task automatic send_beat(input logic [DW-1:0] d, input bit last);
    bit acc;
    int guard;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    acc      = 1'b0;
    guard    = 0;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      guard++;
    end
    if (!acc) begin
      check("beat_accept_timeout", 64'(0), 64'(1));
    end else begin
      m_sum += longint'($signed(d));
      m_cnt++;
      if (last || m_cnt == MT) begin
        exp_q.push_back(model_result(m_sum, m_cnt, !last));
        m_sum = 0;
        m_cnt = 0;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    in_valid   = 1'b0;
    guard      = 0;
    while (out_valid && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    check("drain_queue_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_data"},  64'(out_data),  64'(0));
    check({tag, "_flags"}, 64'({out_sat, out_err}), 64'(0));
    check({tag, "_count"}, 64'(out_count), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] rnd_tab [4];
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check("reset_in_ready", 64'(in_ready), 64'(1));

    // Three-term run of 1.0 with latency check.
    send_beat(32'h0004_0000, 1'b0);
    send_beat(32'h0004_0000, 1'b0);
    check("three_no_early_valid", 64'(out_valid), 64'(0));
    send_beat(32'h0004_0000, 1'b1);
    check("three_latency_valid", 64'(out_valid), 64'(1));
    drain();

    // Rounding on single-term runs, back to back.
    send_beat(32'h0000_0100, 1'b1);
    send_beat(32'hFFFF_FF00, 1'b1);
    send_beat(32'h0000_00FF, 1'b1);
    send_beat(32'hFFFF_FEFF, 1'b1);
    drain();

    // Saturation both ways, and a cancelling pair.
    send_beat(32'h7FFF_FFFF, 1'b0);
    send_beat(32'h7FFF_FFFF, 1'b1);
    send_beat(32'h8000_0000, 1'b0);
    send_beat(32'h8000_0000, 1'b1);
    send_beat(32'h7FFF_FFFF, 1'b0);
    send_beat(32'h8000_0000, 1'b1);
    drain();

    // Stall: result held while a second final beat waits.
    out_ready = 1'b0;
    send_beat(32'h0004_0000, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'h0008_0000;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'(0));
      check("stall_hold_data", 64'(out_data), 64'(16'h0200));
      check("stall_hold_valid", 64'(out_valid), 64'(1));
      tick();
    end
    out_ready = 1'b1;
    send_beat(32'h0008_0000, 1'b1);
    check("stall_no_bubble_valid", 64'(out_valid), 64'(1));
    check("stall_no_bubble_data", 64'(out_data), 64'(16'h0400));
    drain();

    // Max terms force-termination, then a fresh run.
    for (int i = 0; i < MT; i++) send_beat(32'h0000_1000, 1'b0);
    send_beat(32'h0004_0000, 1'b1);
    drain();

    // Reset mid-run discards the partial sum.
    send_beat(32'h0004_0000, 1'b0);
    send_beat(32'h0004_0000, 1'b0);
    rst = 1'b1;
    tick();
    check_all_zero("midrst_during");
    rst   = 1'b0;
    m_sum = 0;
    m_cnt = 0;
    @(negedge clk);
    check_all_zero("midrst_after");
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    tick();
    send_beat(32'h0004_0000, 1'b1);
    drain();

    // Random runs with random output backpressure.
    rnd_tab[0] = 32'h7FFF_FFFF;
    rnd_tab[1] = 32'h8000_0000;
    rnd_tab[2] = 32'h0000_0100;
    rnd_tab[3] = 32'hFFFF_FF00;
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [DW-1:0] d;
      case ($urandom_range(0, 3))
        0:       d = DW'($urandom);
        1:       d = rnd_tab[$urandom_range(0, 3)];
        default: d = DW'($signed(20'($urandom)));
      endcase
      send_beat(d, ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 5) == 0) tick();
    end
    send_beat(32'h0000_0000, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mac_acc_requant.md
Name: mac_acc_requant

Overview:
- Downstream stage of the MAC processing element.
- Consumes the full-width signed product-plus-addend stream (Q(2I).(2F), 2*(I+F) bits).
- Accumulates a variable-length run of terms in a guard-bit-extended accumulator.
- Rounds, saturates and requantizes the total back to the native Q(I).(F) word, then presents it on a valid/ready output with error flags.

Parameters:
- para_int_bits, 7, integer bits I of the native fixed-point word (sign included).
- para_frac_bits, 9, fraction bits F of the native word; input carries 2F fraction bits.
- para_max_terms, 64, maximum terms per run; power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts beat this cycle.
- in_data  input  2*(I+F)=32  signed Q14.18 MAC result.
- in_last  input  1  marks final term of current run.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  I+F=16  signed Q7.9 requantized sum.
- out_sat  output  1  result was clipped during saturation.
- out_err  output  1  run force-terminated at para_max_terms without in_last.
- out_count  output  clog2(para_max_terms)+1  number of terms in the emitted run.

Behaviour:
- Sizing: W=I+F; accumulator width ACC_W = 2W + clog2(para_max_terms) = 38 by default; in_data sign-extended to ACC_W; the accumulator cannot overflow internally.
- Accept: a beat is accepted when in_valid && in_ready.
- Ready rule: in_ready = !out_valid || out_ready, combinational from the output register state. No other backpressure source.
- Non-final beat (in_last=0 and term count+1 < para_max_terms): acc <= acc + in_data; cnt <= cnt + 1.
- Final beat (in_last=1, or cnt+1 == para_max_terms):
  - Compute total T = acc + in_data.
  - Load the output register: out_valid <= 1, out_count <= cnt + 1, out_err <= !in_last.
  - Same cycle: acc <= 0, cnt <= 0.
- Latency: out_valid rises the cycle after the final beat is accepted.
- Throughput: one result per cycle for back-to-back single-term runs when out_ready=1.
- Requant (combinational on T, registered into out_data):
  - Add 2^(F-1) (round half toward +inf).
  - Arithmetic shift right by F (2F to F fraction bits).
  - Saturate to [-2^(W-1), 2^(W-1)-1]; out_sat=1 iff clipped.
- Output register:
  - Holds out_data, out_sat, out_err and out_count stable while out_valid && !out_ready.
  - Cleared to out_valid=0 when out_ready && out_valid and no new final beat arrives that cycle.
- Simultaneous drain and final-beat accept: the new result overwrites the register; out_valid stays 1; no bubble.
- States:
  - EMPTY: cnt=0, no result pending.
  - ACCUM: cnt>0.
  - HOLD: out_valid=1.
  - HOLD is orthogonal to EMPTY/ACCUM. Non-final beats are accepted only when in_ready=1; while stalled, the accumulator freezes.
- Reset (any time, including mid-run or with result pending):
  - acc=0, cnt=0.
  - out_valid=0, out_data=0, out_sat=0, out_err=0, out_count=0.
  - in_ready=1 in the first cycle after rst deasserts; the partial run is discarded.
- in_data, in_last and in_valid are ignored when in_ready=0.

Test Plan:
- Three-term run: beats 0x00040000 (1.0*1.0) x3, last on the 3rd, out_ready=1 -> out_valid one cycle after the 3rd beat; out_data=0x0600, out_sat=0, out_err=0, out_count=3.
- Rounding on single-term runs:
  - 0x00000100 -> out_data=0x0001.
  - 0xFFFFFF00 -> 0x0000.
  - 0x000000FF -> 0x0000.
  - 0xFFFFFEFF -> 0xFFFF.
- Saturation:
  - Two-term run 0x7FFFFFFF, 0x7FFFFFFF -> out_data=0x7FFF, out_sat=1.
  - Two-term run 0x80000000, 0x80000000 -> out_data=0x8000, out_sat=1.
  - Run of 0x7FFFFFFF, 0x80000000 -> 0x0000, out_sat=0.
- Stall: out_ready=0, complete run (single beat 0x00040000), then present a last beat 0x00080000 for 5 cycles.
  - in_ready=0 throughout; out_data holds 0x0200.
  - Raise out_ready: the same cycle accepts the second beat; the next cycle shows out_data=0x0400 with no bubble.
- Max terms: 64 beats of 0x00001000 with in_last=0 -> emitted after the 64th; out_data=0x0200, out_err=1, out_count=64; the 65th beat starts a fresh run.
- Reset mid-run: two beats of 0x00040000, assert rst one cycle, then one last beat 0x00040000 -> out_data=0x0200, out_count=1; all outputs 0 during and immediately after reset.
